handle_remote_shift: RTL and testbench
======================================

Name: handle_remote_shift

Overview:
- Receive-side counterpart of the local shift sender.
- Consumes a decoded interboard shift message and applies the same card-run shift to the local table map, so the opponent's move appears on this board.
- Uses a sequential read/write walk over the map RAM.
- Sits between the interboard receiver and the table map memory, beside the other game-control handlers.

Parameters:
- PLAYER, 0, board identity; only messages from the other player are applied.
- COLS, 18, table columns per row; valid x is 0..COLS-1.
- MSG_SHIFT, 4'd3, shift message code; must equal the shift code in message_macro.v.
- EMPTY_CARD, 6'd54, card code written into vacated cells.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- interboard_rst  in  1  synchronous abort; forces IDLE, same output values as rst.
- interboard_en  in  1  one-cycle pulse; message fields valid this cycle.
- interboard_msg_type  in  4  message type.
- interboard_move_dir  in  1  0 = left, 1 = right.
- interboard_block_x  in  5  leftmost column of the selected run.
- interboard_block_y  in  3  row of the run.
- interboard_card  in  6  first card of the run; latched only, not used for addressing.
- interboard_sel_len  in  3  run length, 1..7.
- map_rd_x  out  5  map read column.
- map_rd_y  out  3  map read row.
- map_rd_data  in  6  read data, valid one cycle after address.
- map_wr_en  out  1  map write strobe.
- map_wr_x  out  5  write column.
- map_wr_y  out  3  write row.
- map_wr_data  out  6  write data.
- busy  out  1  high from accept until the cycle after done.
- remote_shift_done  out  1  one-cycle pulse; shift fully written.
- remote_shift_err  out  1  one-cycle pulse; message rejected.
- remote_sel_x  out  5  new leftmost column of the run after shift.

Behaviour:
- Reset (rst or interboard_rst): state IDLE; all outputs 0; remote_sel_x = 0; latched fields cleared.
- Accept rule: in IDLE, if interboard_en=1 and interboard_msg_type==MSG_SHIFT, latch all fields at that edge.
- Messages with any other msg_type are ignored; no error.
- Validation, checked at the accept edge:
  - sel_len==0 -> reject.
  - Right move with x+len > COLS-1 -> reject.
  - Left move with x==0 -> reject.
  - Reject = remote_shift_err pulse on the next cycle, no map writes, stay IDLE.
- A message arriving while busy is dropped and produces a remote_shift_err pulse; the running shift continues unaffected.
- FSM: IDLE -> READ -> WAIT -> WRITE -> (next card ? READ : CLEAR) -> DONE -> IDLE.
- Right walk: index i runs len-1 down to 0. Read (x+i,y), write the data to (x+i+1,y). CLEAR writes EMPTY_CARD to (x,y). remote_sel_x = x+1.
- Left walk: index i runs 0 up to len-1. Read (x+i,y), write to (x+i-1,y). CLEAR writes EMPTY_CARD to (x+len-1,y). remote_sel_x = x-1.
- READ drives map_rd_x/y. WAIT holds them. WRITE asserts map_wr_en with map_wr_data = map_rd_data.
- map_wr_en is high only in WRITE and CLEAR. Exactly len+1 writes per accepted message.
- Latency: counting the cycle after the accept edge as cycle 1, done pulses in cycle 3*len+2 and busy drops the following cycle.
- Index arithmetic uses 6-bit intermediates so x+len cannot wrap.
- remote_sel_x updates in DONE and holds until the next DONE or reset.
- rst or interboard_rst mid-walk: abort immediately, no further writes, no done pulse. Cells already written stay written.
- Simultaneous interboard_en with interboard_rst: reset wins; the message is dropped.

Test Plan:
- Right shift, x=3, y=1, len=2, map row1 cols3..5 = {10,11,EMPTY}:
  - Writes in order: (5)=11, (4)=10, (3)=EMPTY.
  - done pulses in cycle 8; remote_sel_x=4.
- Left shift, x=5, y=0, len=3, row0 cols4..7 = {EMPTY,20,21,22}:
  - Writes in order: (4)=20, (5)=21, (6)=22, (7)=EMPTY.
  - done in cycle 11; remote_sel_x=4.
- Boundary rejects: right x=15, len=3 (15+3 > 17); left x=0, len=1; len=0.
  - Each -> err pulse one cycle after accept, zero map_wr_en, busy stays 0.
- Non-shift msg_type (4'd1) with en -> no response at all.
- Shift message mid-walk -> err pulse; the original shift completes with correct writes.
- rst asserted asynchronously in WAIT of card 2 -> outputs 0 immediately, no done pulse.
  - Repeat with interboard_rst -> same result at the next edge.
  - Afterwards a fresh message is accepted normally.

Source files
------------

// File: rtl/handle_remote_shift.sv
// Applies an opponent's card-run shift to the local table map by walking the
// run through the map RAM one read/write pair at a time.
module handle_remote_shift #(
  parameter int          PLAYER     = 0,
  parameter int          COLS       = 18,
  parameter logic [3:0]  MSG_SHIFT  = 4'd3,
  parameter logic [5:0]  EMPTY_CARD = 6'd54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       interboard_en,
  input  logic [3:0] interboard_msg_type,
  input  logic       interboard_move_dir,
  input  logic [4:0] interboard_block_x,
  input  logic [2:0] interboard_block_y,
  input  logic [5:0] interboard_card,
  input  logic [2:0] interboard_sel_len,
  output logic [4:0] map_rd_x,
  output logic [2:0] map_rd_y,
  input  logic [5:0] map_rd_data,
  output logic       map_wr_en,
  output logic [4:0] map_wr_x,
  output logic [2:0] map_wr_y,
  output logic [5:0] map_wr_data,
  output logic       busy,
  output logic       remote_shift_done,
  output logic       remote_shift_err,
  output logic [4:0] remote_sel_x
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_CLEAR, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic [4:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic [2:0] len_q, len_d;
  logic [5:0] card_q, card_d;
  logic [2:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic [4:0] sel_x_q, sel_x_d;

  logic       accept;
  logic       bad_msg;
  logic       last_card;
  logic [5:0] end6;
  logic [5:0] rd6;
  logic [5:0] wr6;
  logic [5:0] clr6;
  logic       unused_ok;

  // The card code travels with the message but plays no part in addressing.
  assign unused_ok = ^{card_q, 1'(PLAYER)};

  assign accept    = interboard_en && (interboard_msg_type == MSG_SHIFT);
  assign end6      = {1'b0, interboard_block_x} + {3'b000, interboard_sel_len};
  assign bad_msg   = (interboard_sel_len == 3'd0) ||
                     (interboard_move_dir && (end6 > 6'(COLS - 1))) ||
                     (!interboard_move_dir && (interboard_block_x == 5'd0));
  assign last_card = dir_q ? (idx_q == 3'd0) : (idx_q == len_q - 3'd1);
  assign rd6       = {1'b0, x_q} + {3'b000, idx_q};
  assign wr6       = dir_q ? rd6 + 6'd1 : rd6 - 6'd1;
  assign clr6      = dir_q ? {1'b0, x_q} : {1'b0, x_q} + {3'b000, len_q} - 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      len_q   <= '0;
      card_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      sel_x_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      len_q   <= len_d;
      card_q  <= card_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      sel_x_q <= sel_x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    len_d   = len_q;
    card_d  = card_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    sel_x_d = sel_x_q;

    // A second shift request while walking is dropped but reported.
    if (accept && (state_q != S_IDLE)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dir_d  = interboard_move_dir;
          x_d    = interboard_block_x;
          y_d    = interboard_block_y;
          len_d  = interboard_sel_len;
          card_d = interboard_card;
          if (bad_msg) begin
            err_d = 1'b1;
          end else begin
            state_d = S_READ;
            idx_d   = interboard_move_dir ? interboard_sel_len - 3'd1 : 3'd0;
          end
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = S_WRITE;
      S_WRITE: begin
        if (last_card) begin
          state_d = S_CLEAR;
        end else begin
          idx_d   = dir_q ? idx_q - 3'd1 : idx_q + 3'd1;
          state_d = S_READ;
        end
      end
      S_CLEAR: begin
        state_d = S_DONE;
        sel_x_d = dir_q ? x_q + 5'd1 : x_q - 5'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (interboard_rst) begin
      state_d = S_IDLE;
      dir_d   = 1'b0;
      x_d     = '0;
      y_d     = '0;
      len_d   = '0;
      card_d  = '0;
      idx_d   = '0;
      err_d   = 1'b0;
      sel_x_d = '0;
    end
  end

  always_comb begin
    map_rd_x          = '0;
    map_rd_y          = '0;
    map_wr_en         = 1'b0;
    map_wr_x          = '0;
    map_wr_y          = '0;
    map_wr_data       = '0;
    busy              = (state_q != S_IDLE);
    remote_shift_done = (state_q == S_DONE);
    remote_shift_err  = err_q;
    remote_sel_x      = sel_x_q;

    // The read address stays put through WRITE so the RAM data is stable.
    if ((state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE)) begin
      map_rd_x = rd6[4:0];
      map_rd_y = y_q;
    end
    if (state_q == S_WRITE) begin
      map_wr_en   = 1'b1;
      map_wr_x    = wr6[4:0];
      map_wr_y    = y_q;
      map_wr_data = map_rd_data;
    end else if (state_q == S_CLEAR) begin
      map_wr_en   = 1'b1;
      map_wr_x    = clr6[4:0];
      map_wr_y    = y_q;
      map_wr_data = EMPTY_CARD;
    end
  end

endmodule

// File: tb/tb_handle_remote_shift.sv
// Directed bench for handle_remote_shift: a small map RAM model, a table of
// shift messages with hand-computed write sequences, and reset-abort sequences.
module tb_handle_remote_shift;

  localparam logic [3:0] MSG_SHIFT = 4'd3;
  localparam logic [5:0] EMPTY     = 6'd54;

  logic       clk;
  logic       rst;
  logic       interboardRst;
  logic       interboardEn;
  logic [3:0] msgType;
  logic       moveDir;
  logic [4:0] blockX;
  logic [2:0] blockY;
  logic [5:0] card;
  logic [2:0] selLen;
  logic [4:0] map_rd_x;
  logic [2:0] map_rd_y;
  logic [5:0] map_rd_data;
  logic       map_wr_en;
  logic [4:0] map_wr_x;
  logic [2:0] map_wr_y;
  logic [5:0] map_wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] selX;

  int checks = 0;
  int errors = 0;

  logic [5:0] mem [0:7][0:31];
  logic       plEn;
  logic [4:0] plX;
  logic [2:0] plY;
  logic [5:0] plD;

  int         wrCount = 0;
  logic [4:0] wrX [0:255];
  logic [2:0] wrY [0:255];
  logic [5:0] wrD [0:255];

  typedef struct {
    logic       dir;
    logic [4:0] x;
    logic [2:0] y;
    logic [2:0] len;
    logic [3:0] msg;
    int         injectCycle;
    int         expErrCycle;
    int         expDoneCycle;
    logic [4:0] expSelX;
    int         nWr;
    logic [3:0][4:0] wx;
    logic [3:0][5:0] wd;
  } vec_t;

  vec_t vecs [9];
  vec_t freshVec;

  handle_remote_shift dut (
    .clk                 (clk),
    .rst                 (rst),
    .interboard_rst      (interboardRst),
    .interboard_en       (interboardEn),
    .interboard_msg_type (msgType),
    .interboard_move_dir (moveDir),
    .interboard_block_x  (blockX),
    .interboard_block_y  (blockY),
    .interboard_card     (card),
    .interboard_sel_len  (selLen),
    .map_rd_x            (map_rd_x),
    .map_rd_y            (map_rd_y),
    .map_rd_data         (map_rd_data),
    .map_wr_en           (map_wr_en),
    .map_wr_x            (map_wr_x),
    .map_wr_y            (map_wr_y),
    .map_wr_data         (map_wr_data),
    .busy                (busy),
    .remote_shift_done   (done),
    .remote_shift_err    (err),
    .remote_sel_x        (selX)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map RAM model: one-cycle read latency, writes from the DUT or from preload
  always @(posedge clk) begin
    if (plEn) mem[plY][plX] <= plD;
    if (map_wr_en) mem[map_wr_y][map_wr_x] <= map_wr_data;
    map_rd_data <= mem[map_rd_y][map_rd_x];
  end

  // Log every DUT write in order so write sequences can be checked afterwards
  always @(posedge clk) begin
    if (map_wr_en) begin
      wrX[wrCount[7:0]] <= map_wr_x;
      wrY[wrCount[7:0]] <= map_wr_y;
      wrD[wrCount[7:0]] <= map_wr_data;
      wrCount <= wrCount + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dir, input logic [4:0] x, input logic [2:0] y,
                               input logic [2:0] len, input logic [3:0] msg);
    moveDir      = dir;
    blockX       = x;
    blockY       = y;
    selLen       = len;
    msgType      = msg;
    card         = 6'd33;
    interboardEn = 1'b1;
  endtask

  task automatic preload(input logic [4:0] x, input logic [2:0] y, input logic [5:0] d);
    @(negedge clk);
    plX  = x;
    plY  = y;
    plD  = d;
    plEn = 1'b1;
    @(negedge clk);
    plEn = 1'b0;
  endtask

  // Sends one message, observes 40 cycles (cycle 1 = cycle after accept), then compares
  task automatic runVector(input vec_t v, input string tag);
    int errCyc, errCnt, doneCyc, doneCnt, lastBusy, wrBase;
    errCyc = 0; errCnt = 0; doneCyc = 0; doneCnt = 0; lastBusy = 0;
    wrBase = wrCount;
    @(negedge clk);
    applyStimulus(v.dir, v.x, v.y, v.len, v.msg);
    @(negedge clk);
    interboardEn = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (err) begin errCnt++; if (errCyc == 0) errCyc = cyc; end
      if (done) begin doneCnt++; if (doneCyc == 0) doneCyc = cyc; end
      if (busy) lastBusy = cyc;
      if (cyc == v.injectCycle) applyStimulus(1'b1, 5'd0, v.y, 3'd1, MSG_SHIFT);
      else interboardEn = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, " err cycle"}, errCyc, v.expErrCycle);
    checkOutput({tag, " err pulses"}, errCnt, (v.expErrCycle != 0) ? 1 : 0);
    checkOutput({tag, " done cycle"}, doneCyc, v.expDoneCycle);
    checkOutput({tag, " done pulses"}, doneCnt, (v.expDoneCycle != 0) ? 1 : 0);
    checkOutput({tag, " last busy cycle"}, lastBusy, v.expDoneCycle);
    checkOutput({tag, " write count"}, wrCount - wrBase, v.nWr);
    for (int i = 0; i < v.nWr; i++) begin
      checkOutput({tag, $sformatf(" write%0d x", i)}, int'(wrX[wrBase + i]), int'(v.wx[i]));
      checkOutput({tag, $sformatf(" write%0d y", i)}, int'(wrY[wrBase + i]), int'(v.y));
      checkOutput({tag, $sformatf(" write%0d data", i)}, int'(wrD[wrBase + i]), int'(v.wd[i]));
    end
    checkOutput({tag, " sel_x"}, int'(selX), int'(v.expSelX));
  endtask

  // Starts a right shift x=3 len=2 and kills it during WAIT of the second card
  task automatic abortTest(input logic useSync, input logic [2:0] row, input logic [5:0] firstData,
                           input string tag);
    int wrBase, doneCnt;
    wrBase = wrCount;
    doneCnt = 0;
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, row, 3'd2, MSG_SHIFT);
    @(negedge clk);
    interboardEn = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput({tag, " busy before abort"}, int'(busy), 1);
    if (!useSync) begin
      rst = 1'b1;
      #1;
    end else begin
      interboardRst = 1'b1;
      @(negedge clk);
    end
    checkOutput({tag, " busy after abort"}, int'(busy), 0);
    checkOutput({tag, " wr_en after abort"}, int'(map_wr_en), 0);
    checkOutput({tag, " rd_x after abort"}, int'(map_rd_x), 0);
    checkOutput({tag, " rd_y after abort"}, int'(map_rd_y), 0);
    checkOutput({tag, " sel_x after abort"}, int'(selX), 0);
    @(negedge clk);
    rst = 1'b0;
    interboardRst = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (done) doneCnt++;
      @(negedge clk);
    end
    checkOutput({tag, " done pulses"}, doneCnt, 0);
    checkOutput({tag, " write count"}, wrCount - wrBase, 1);
    checkOutput({tag, " write0 x"}, int'(wrX[wrBase]), 5);
    checkOutput({tag, " write0 data"}, int'(wrD[wrBase]), int'(firstData));
  endtask

  // Main sequence: reset checks, vector table, abort sequences, fresh message
  initial begin
    rst = 1'b1; interboardRst = 1'b0; interboardEn = 1'b0;
    msgType = '0; moveDir = 1'b0; blockX = '0; blockY = '0; card = '0; selLen = '0;
    plEn = 1'b0; plX = '0; plY = '0; plD = '0;

    // Write lists are packed with entry 0 rightmost
    vecs[0] = '{1'b1, 5'd3, 3'd1, 3'd2, MSG_SHIFT, 0, 0, 8, 5'd4, 3,
                {5'd0, 5'd3, 5'd4, 5'd5}, {6'd0, EMPTY, 6'd10, 6'd11}};
    vecs[1] = '{1'b0, 5'd5, 3'd0, 3'd3, MSG_SHIFT, 0, 0, 11, 5'd4, 4,
                {5'd7, 5'd6, 5'd5, 5'd4}, {EMPTY, 6'd22, 6'd21, 6'd20}};
    vecs[2] = '{1'b1, 5'd14, 3'd2, 3'd3, MSG_SHIFT, 0, 0, 11, 5'd15, 4,
                {5'd14, 5'd15, 5'd16, 5'd17}, {EMPTY, 6'd1, 6'd2, 6'd3}};
    vecs[3] = '{1'b1, 5'd15, 3'd2, 3'd3, MSG_SHIFT, 0, 1, 0, 5'd15, 0, '0, '0};
    vecs[4] = '{1'b0, 5'd0, 3'd2, 3'd1, MSG_SHIFT, 0, 1, 0, 5'd15, 0, '0, '0};
    vecs[5] = '{1'b1, 5'd2, 3'd2, 3'd0, MSG_SHIFT, 0, 1, 0, 5'd15, 0, '0, '0};
    vecs[6] = '{1'b1, 5'd3, 3'd1, 3'd2, 4'd1, 0, 0, 0, 5'd15, 0, '0, '0};
    vecs[7] = '{1'b0, 5'd1, 3'd3, 3'd1, MSG_SHIFT, 0, 0, 5, 5'd0, 2,
                {5'd0, 5'd0, 5'd1, 5'd0}, {6'd0, 6'd0, EMPTY, 6'd7}};
    vecs[8] = '{1'b1, 5'd3, 3'd4, 3'd2, MSG_SHIFT, 3, 4, 8, 5'd4, 3,
                {5'd0, 5'd3, 5'd4, 5'd5}, {6'd0, EMPTY, 6'd30, 6'd31}};
    freshVec = '{1'b1, 5'd6, 3'd7, 3'd1, MSG_SHIFT, 0, 0, 5, 5'd7, 2,
                 {5'd0, 5'd0, 5'd6, 5'd7}, {6'd0, 6'd0, EMPTY, 6'd9}};

    #1;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset wr_en", int'(map_wr_en), 0);
    checkOutput("reset sel_x", int'(selX), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    preload(5'd3, 3'd1, 6'd10); preload(5'd4, 3'd1, 6'd11); preload(5'd5, 3'd1, EMPTY);
    preload(5'd4, 3'd0, EMPTY); preload(5'd5, 3'd0, 6'd20);
    preload(5'd6, 3'd0, 6'd21); preload(5'd7, 3'd0, 6'd22);
    preload(5'd14, 3'd2, 6'd1); preload(5'd15, 3'd2, 6'd2); preload(5'd16, 3'd2, 6'd3);
    preload(5'd1, 3'd3, 6'd7);
    preload(5'd3, 3'd4, 6'd30); preload(5'd4, 3'd4, 6'd31); preload(5'd5, 3'd4, EMPTY);
    preload(5'd3, 3'd5, 6'd40); preload(5'd4, 3'd5, 6'd41);
    preload(5'd3, 3'd6, 6'd50); preload(5'd4, 3'd6, 6'd51);
    preload(5'd6, 3'd7, 6'd9);

    for (int i = 0; i < 9; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    abortTest(1'b0, 3'd5, 6'd41, "async rst abort");
    abortTest(1'b1, 3'd6, 6'd51, "sync rst abort");

    // Message coinciding with interboard_rst must be dropped
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, 3'd1, 3'd1, MSG_SHIFT);
    interboardRst = 1'b1;
    @(negedge clk);
    interboardEn = 1'b0;
    interboardRst = 1'b0;
    checkOutput("en with sync rst busy", int'(busy), 0);
    checkOutput("en with sync rst err", int'(err), 0);
    @(negedge clk);
    checkOutput("en with sync rst busy later", int'(busy), 0);

    runVector(freshVec, "fresh after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
